// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Also holds the memory map seen by the core.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_BASE  = 32'h2000_0000;

  // Wait counter and streak counter share this width (both parameters are 1..15).
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_priority.sv
// Grant decision between the fetch and load/store ports, plus the next
// value of the consecutive-data-grant streak counter.
module arb_priority
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] streak,
  output logic             grant_i,
  output logic             grant_d,
  output logic [CNT_W-1:0] streak_next
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  always_comb begin
    // Data wins unless a fetch has been starved for STREAK_MAX data grants.
    grant_i     = i_req && (!d_req || (streak == STREAK_MAX));
    grant_d     = d_req && !grant_i;
    streak_next = streak;
    if (grant_i) begin
      streak_next = '0;
    end else if (grant_d) begin
      if (!i_req) begin
        streak_next = '0;
      end else if (streak < STREAK_MAX) begin
        streak_next = streak + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported memory subsystem between the instruction-fetch and
// load/store ports: grant, WAIT_CYCLES access window, one-cycle ack.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [2:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic             owner_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] streak;
  logic [CNT_W-1:0] streak_next;
  logic [2:0]       we_lat;
  logic             grant_i;
  logic             grant_d;

  arb_priority #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .streak     (streak),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .streak_next(streak_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner_d <= 1'b0;
      cnt     <= '0;
      streak  <= '0;
      we_lat  <= WE_NONE;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      m_addr  <= '0;
      m_we    <= WE_NONE;
      m_wdata <= '0;
      busy    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            state   <= ST_ACCESS;
            busy    <= 1'b1;
            owner_d <= grant_d;
            streak  <= streak_next;
            cnt     <= WAIT_LOAD;
            if (grant_d) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              we_lat  <= d_we;
              m_we    <= (WAIT_LOAD == '0) ? d_we : WE_NONE;
            end else begin
              m_addr  <= i_addr;
              we_lat  <= WE_NONE;
              m_we    <= WE_NONE;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state <= ST_RESP;
            m_we  <= WE_NONE;
            if (owner_d) begin
              d_rdata <= m_rdata;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            // m_we is registered, so it is raised one edge ahead of the cnt==0 cycle.
            m_we <= (cnt == CNT_W'(1)) ? we_lat : WE_NONE;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          m_we  <= WE_NONE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          m_we  <= WE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: a WAIT_CYCLES=3 instance on a
// small ROM/RAM/GPIO model plus a WAIT_CYCLES=1 instance for the lone-fetch case.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_we;
  logic        i_ack, d_ack, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [2:0]  m_we;

  logic        f_i_req;
  logic [31:0] f_i_addr;
  logic        f_i_ack, f_d_ack, f_busy;
  logic [31:0] f_i_rdata, f_d_rdata, f_m_addr, f_m_wdata, f_m_rdata;
  logic [2:0]  f_m_we;

  mem_bus_arbiter #(.WAIT_CYCLES(W), .MAX_D_STREAK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(1), .MAX_D_STREAK(4)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
    .d_req(1'b0), .d_addr(32'h0), .d_we(3'b000), .d_wdata(32'h0),
    .d_ack(f_d_ack), .d_rdata(f_d_rdata),
    .m_addr(f_m_addr), .m_we(f_m_we), .m_wdata(f_m_wdata), .m_rdata(f_m_rdata),
    .busy(f_busy)
  );

  // Memory subsystem model: word > half > byte strobe priority.
  logic [31:0] ram [16] = '{default: '0};
  logic [31:0] gpio = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [2:0] we, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    if (we[0]) r = wd;
    else if (we[1]) begin
      if (a[1]) r[31:16] = wd[15:0];
      else r[15:0] = wd[15:0];
    end else if (we[2]) r[int'(a)*8 +: 8] = wd[7:0];
    return r;
  endfunction

  always @(posedge clk) begin
    if (m_we != WE_NONE) begin
      if ((m_addr & 32'hF000_0000) == RAM_BASE)
        ram[m_addr[5:2]] <= merge(ram[m_addr[5:2]], m_wdata, m_we, m_addr[1:0]);
      else if ((m_addr & 32'hF000_0000) == IO_BASE)
        gpio <= merge(gpio, m_wdata, m_we, m_addr[1:0]);
    end
  end

  always_comb begin
    m_rdata = '0;
    if ((m_addr & 32'hF000_0000) == ROM_BASE)
      m_rdata = (m_addr[5:2] == 4'd1) ? 32'h0000_0093 : 32'h0000_0013;
    else if ((m_addr & 32'hF000_0000) == RAM_BASE)
      m_rdata = ram[m_addr[5:2]];
    else if ((m_addr & 32'hF000_0000) == IO_BASE)
      m_rdata = gpio;
  end

  assign f_m_rdata = (f_m_addr == 32'h0000_0004) ? 32'h0000_0093 : 32'h0;

  // Bus monitors sampled on the falling edge.
  int          cyc = 0;
  int          we_cnt = 0, dack_cnt = 0, we_at = 0;
  logic [2:0]  we_last = '0;
  logic [31:0] we_data = '0;
  int          f_we_cnt = 0, f_iack_cnt = 0, f_dack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_we != WE_NONE) begin
      we_cnt  <= we_cnt + 1;
      we_last <= m_we;
      we_at   <= cyc;
      we_data <= m_wdata;
    end
    if (d_ack) dack_cnt <= dack_cnt + 1;
    if (f_m_we != WE_NONE) f_we_cnt <= f_we_cnt + 1;
    if (f_i_ack) f_iack_cnt <= f_iack_cnt + 1;
    if (f_d_ack) f_dack_cnt <= f_dack_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(output logic is_d, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_ack || d_ack) && n < 40);
    chk("ack_seen", 32'(i_ack | d_ack), 32'd1);
    is_d = d_ack;
    at   = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic isd;
    int   c, at, prev, n, we0, dk0;
    bit   exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    i_addr = '0; d_addr = '0; d_we = WE_NONE; d_wdata = '0;
    f_i_req = 1'b0; f_i_addr = '0;
    idle(2);
    chk("rst_i_ack", 32'(i_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_f_busy", 32'(f_busy), 0);
    rst_n = 1'b1;
    idle(1);

    // Lone fetch on the WAIT_CYCLES=1 instance.
    f_i_addr = 32'h0000_0004;
    f_i_req  = 1'b1;
    c = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!f_i_ack && n < 20);
    at = cyc;
    chk("f_ack_seen", 32'(f_i_ack), 1);
    chk("f_latency", 32'(at - c), 2);
    chk("f_i_rdata", f_i_rdata, 32'h0000_0093);
    f_i_req = 1'b0;
    idle(3);
    chk("f_iack_pulses", 32'(f_iack_cnt), 1);
    chk("f_we_cycles", 32'(f_we_cnt), 0);
    chk("f_dack_pulses", 32'(f_dack_cnt), 0);
    chk("f_d_rdata", f_d_rdata, 0);
    chk("f_m_wdata", f_m_wdata, 0);

    // Store word, then load it back.
    we0 = we_cnt;
    d_addr = RAM_BASE + 32'h10; d_we = WE_WORD; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    c = cyc;
    idle(1);
    chk("st_busy", 32'(busy), 1);
    chk("st_we_early", 32'(m_we), 0);
    chk("st_m_addr", m_addr, 32'h1000_0010);
    wait_ack(isd, at);
    d_req = 1'b0;
    chk("st_owner_d", 32'(isd), 1);
    chk("st_latency", 32'(at - c), W + 1);
    idle(1);
    chk("st_we_cycles", 32'(we_cnt - we0), 1);
    chk("st_we_val", 32'(we_last), 32'(WE_WORD));
    chk("st_we_cycle", 32'(we_at - c), W);
    chk("st_we_data", we_data, 32'hDEAD_BEEF);
    we0 = we_cnt;
    d_we = WE_NONE; d_req = 1'b1;
    wait_ack(isd, at);
    d_req = 1'b0;
    chk("ld_owner_d", 32'(isd), 1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    idle(1);
    chk("ld_no_we", 32'(we_cnt - we0), 0);

    // Byte store to GPIO, then read back.
    we0 = we_cnt;
    d_addr = IO_BASE; d_we = WE_BYTE; d_wdata = 32'h0000_00A5; d_req = 1'b1;
    wait_ack(isd, at);
    d_req = 1'b0;
    idle(1);
    chk("io_we_cycles", 32'(we_cnt - we0), 1);
    chk("io_we_val", 32'(we_last), 32'(WE_BYTE));
    d_we = WE_NONE; d_req = 1'b1;
    wait_ack(isd, at);
    d_req = 1'b0;
    chk("io_rdata", d_rdata, 32'h0000_00A5);
    chk("io_i_rdata_hold", i_rdata, 0);
    idle(1);

    // Simultaneous first requests after reset: data first, then fetch.
    do_reset();
    i_addr = 32'h0000_0004; i_req = 1'b1;
    d_addr = RAM_BASE + 32'h10; d_we = WE_NONE; d_req = 1'b1;
    wait_ack(isd, at);
    chk("sim_first_d", 32'(isd), 1);
    chk("sim_first_no_i", 32'(i_ack), 0);
    chk("sim_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    wait_ack(isd, at);
    i_req = 1'b0;
    chk("sim_second_i", 32'(isd), 0);
    chk("sim_i_rdata", i_rdata, 32'h0000_0093);
    chk("sim_d_rdata_hold", d_rdata, 32'hDEAD_BEEF);
    idle(1);

    // Continuous contention: D,D,D,D,I repeating, one access per W+2 cycles.
    do_reset();
    i_req = 1'b1; d_req = 1'b1;
    c = cyc;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      wait_ack(isd, at);
      chk($sformatf("cont%0d_owner_d", k), 32'(isd), 32'(exp_d[k]));
      if (k == 0) chk("cont_first_latency", 32'(at - c), W + 1);
      else chk($sformatf("cont%0d_gap", k), 32'(at - prev), W + 2);
      prev = at;
    end
    i_req = 1'b0; d_req = 1'b0;
    idle(2);

    // Reset during a store, before its write cycle.
    we0 = we_cnt;
    dk0 = dack_cnt;
    d_addr = RAM_BASE + 32'h20; d_we = WE_WORD; d_wdata = 32'h1234_5678; d_req = 1'b1;
    idle(1);
    chk("ra_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_m_we", 32'(m_we), 0);
    chk("ra_busy_clr", 32'(busy), 0);
    chk("ra_m_addr", m_addr, 0);
    chk("ra_m_wdata", m_wdata, 0);
    chk("ra_d_rdata", d_rdata, 0);
    chk("ra_d_ack", 32'(d_ack), 0);
    d_req = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("ra_we_cycles", 32'(we_cnt - we0), 0);
    chk("ra_dack_pulses", 32'(dack_cnt - dk0), 0);
    d_we = WE_NONE; d_req = 1'b1;
    c = cyc;
    wait_ack(isd, at);
    d_req = 1'b0;
    chk("ra_ld_owner_d", 32'(isd), 1);
    chk("ra_ld_latency", 32'(at - c), W + 1);
    chk("ra_ld_rdata", d_rdata, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-ported memory subsystem (ROM at 0x0000_0000, RAM at 0x1000_0000, GPIO at 0x2000_0000) between the CPU instruction-fetch port and the load/store port.
- Sequences each access as request, N-cycle access window, then a one-cycle acknowledge with registered read data.
- Sits between the core and the memory subsystem. It drives the subsystem's address, write_enable and data_in, and samples data_out.

Parameters:
- WAIT_CYCLES, 1, cycles the granted access is held on the memory bus before the response; legal range 1..15.
- MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request is pending before the fetch port is forced in; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  input  1  fetch request; held high until i_ack.
- i_addr  input  32  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  output  32  registered fetch data.
- d_req  input  1  load/store request; held high until d_ack.
- d_addr  input  32  load/store address.
- d_we  input  3  write strobe: [0] word, [1] half, [2] byte; 0 means load.
- d_wdata  input  32  store data.
- d_ack  output  1  one-cycle pulse: load/store complete, d_rdata valid for loads.
- d_rdata  output  32  registered load data.
- m_addr  output  32  memory subsystem address.
- m_we  output  3  memory subsystem write_enable.
- m_wdata  output  32  memory subsystem data_in.
- m_rdata  input  32  memory subsystem data_out.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; i_ack=d_ack=0; i_rdata=d_rdata=0; m_addr=0; m_we=0; m_wdata=0; busy=0; streak=0; wait counter=0.
  - Reset mid-access abandons the access: no ack, and m_we drops to 0 immediately (asynchronously).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If d_req and i_req are both low, stay in IDLE.
  - Otherwise arbitrate and latch the winner (owner bit, address, we, wdata) into output registers, load wait counter=WAIT_CYCLES-1, and go to ACCESS.
- Arbitration:
  - Data port wins by default.
  - Exception: if i_req is high and streak==MAX_D_STREAK, the fetch port wins.
  - Fetch grant clears streak. Data grant increments streak, saturating at MAX_D_STREAK.
  - Data grant with i_req low also clears streak.
- ACCESS:
  - m_addr and m_wdata hold the latched values.
  - m_we equals the latched d_we only in the last ACCESS cycle (counter==0), and is 0 otherwise. This gives exactly one write edge per store.
  - Fetch grants always drive m_we=0.
  - When counter==0: capture m_rdata into the owner's rdata register, pulse the owner's ack in the next cycle, and go to RESP. Otherwise decrement the counter.
- RESP:
  - Owner's ack=1 for exactly this cycle; m_we=0; go to IDLE.
  - Re-arbitration happens in IDLE, so there is a minimum 1 idle cycle between accesses.
- Latency:
  - Request seen in IDLE at edge k gives ack high in cycle k+WAIT_CYCLES+1.
  - Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Rules:
  - The non-owner's rdata register holds its previous value.
  - Acks are never asserted for a port whose req was low at grant.
  - A request dropped before its ack is a protocol violation. The access completes regardless and the ack is still pulsed.
  - d_we values with multiple bits set are passed through unchanged; the memory subsystem's word>half>byte priority applies.
  - m_addr keeps its last value in IDLE/RESP. Reads there are side-effect free; only m_we matters.
  - Simultaneous first requests after reset: data wins (streak=0).

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE/ST_ACCESS/ST_RESP;
  - write-strobe constants WE_NONE=3'b000, WE_WORD=3'b001, WE_HALF=3'b010, WE_BYTE=3'b100;
  - memory map base constants ROM_BASE, RAM_BASE, IO_BASE.
- One natural sub-module: arb_priority, the combinational grant decision from i_req, d_req and streak, plus the next-streak value. The FSM and datapath registers stay in mem_bus_arbiter.

Test Plan:
- Reset then lone fetch, i_addr=0x0000_0004, m_rdata=0x0000_0093, WAIT_CYCLES=1 -> i_ack pulses exactly 2 cycles after grant edge; i_rdata=0x0000_0093; m_we=0 throughout; d_ack never asserted.
- Store word: d_addr=0x1000_0010, d_we=3'b001, d_wdata=0xDEAD_BEEF, WAIT_CYCLES=3 -> m_we=3'b001 for exactly 1 cycle (the 3rd ACCESS cycle); d_ack pulse follows; a subsequent load of the same address returns 0xDEAD_BEEF.
- Contention with i_req and d_req held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; no gaps beyond 1 IDLE cycle between accesses.
- Simultaneous first request after reset -> data granted first; fetch served next when d_req is low.
- Byte store to GPIO: d_addr=0x2000_0000, d_we=3'b100, d_wdata=0x0000_00A5 -> single m_we pulse; gpio reads back 0xA5.
- rst_n asserted during ACCESS of a store, before the last cycle -> m_we never asserted, no ack, outputs return to reset values immediately; after release a fresh request completes normally.
